// File: rtl/mips_fetch.sv
// Instruction-fetch / next-PC stage. Holds the PC, fetches one word over a
// req/ack handshake, presents it to decode until retired, then advances the
// PC by the retiring instruction's control type. Stops on exception or on
// a misaligned next PC; only reset leaves the halted state.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

  state_t      state;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Next-PC selection for the instruction currently held in inst
  always_comb begin
    br_off  = {{14{inst[15]}}, inst[15:0], 2'b00};
    next_pc = pc_plus4;
    case (control_type)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc_plus4 + br_off;
      2'b10: next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
      2'b11: next_pc = rs_data;
      default: next_pc = pc_plus4;
    endcase
  end

  // Fetch/hold/halt sequencing with all stage outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      inst        <= '0;
      inst_valid  <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
      misalign    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          // Request rises one cycle after reset release; an ack seen while
          // the request is still low belongs to an aborted fetch.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            retired_cnt <= retired_cnt + 32'd1;
            inst_valid  <= 1'b0;
            if (except) begin
              halted <= 1'b1;
              state  <= HALT;
            end else if (next_pc[1:0] != 2'b00) begin
              pc       <= next_pc;
              misalign <= 1'b1;
              halted   <= 1'b1;
              state    <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          inst_valid <= 1'b0;
          imem_req   <= 1'b0;
          halted     <= 1'b1;
        end
        default: begin
          inst_valid <= 1'b0;
          imem_req   <= 1'b0;
          halted     <= 1'b1;
          state      <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: a table of instructions chained through
// the PC, a queue of expected fetch addresses, and hand-written sequences for
// exception halt, misaligned halt and reset during a pending fetch.
module tb_mips_fetch;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  control_type;
  logic        except;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misalign;
  logic [31:0] retired_cnt;

  mips_fetch #(.RESET_PC(RESET_PC)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .control_type (control_type),
    .except       (except),
    .rs_data      (rs_data),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .misalign     (misalign),
    .retired_cnt  (retired_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  ctl;
    logic [31:0] rs;
    int unsigned ack_dly;
    int unsigned rdy_dly;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset      = 1'b0;
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_cnt", retired_cnt, 32'h0);
    @(negedge clock);
    reset   = 1'b1;
    exp_cnt = '0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  // Wait for a request, check its address against the scoreboard, ack after dly cycles
  task automatic fetch(input logic [31:0] word, input int unsigned dly, input logic rdy_early,
                       output int unsigned ack_cyc);
    int unsigned n;
    logic [31:0] e;
    n = 0;
    ack_cyc = 0;
    while (!imem_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got imem_req=0 expected 1 within 50 cycles");
      return;
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got request at 0x%08h expected none", imem_addr);
      return;
    end
    e = exp_q.pop_front();
    chk("imem_addr", imem_addr, e);
    chk("pc_at_fetch", pc, e);
    chk("pc_plus4", pc_plus4, e + 32'd4);
    for (int unsigned i = 0; i < dly; i++) begin
      inst_ready   = rdy_early;
      except       = 1'b1;
      control_type = 2'b11;
      @(negedge clock);
      chk("req_held", {31'b0, imem_req}, 32'h1);
      chk("no_valid_early", {31'b0, inst_valid}, 32'h0);
      chk("cnt_idle", retired_cnt, exp_cnt);
    end
    inst_ready = 1'b0;
    except     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    ack_cyc    = cyc;
    @(negedge clock);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("inst_valid", {31'b0, inst_valid}, 32'h1);
    chk("inst", inst, word);
    chk("req_dropped", {31'b0, imem_req}, 32'h0);
  endtask

  // Hold off retire for hold cycles, then retire once and check the aftermath
  task automatic retire(input logic [1:0] ctl, input logic exc, input logic [31:0] rs,
                        input int unsigned hold, input logic [31:0] exp_pc,
                        input logic exp_halt, input logic exp_mis);
    logic [31:0] p0;
    logic [31:0] i0;
    p0 = pc;
    i0 = inst;
    for (int unsigned i = 0; i < hold; i++) begin
      inst_ready   = 1'b0;
      control_type = ~ctl;
      except       = 1'b1;
      rs_data      = 32'hDEAD_BEE1;
      imem_ack     = 1'b1;
      @(negedge clock);
      chk("hold_pc", pc, p0);
      chk("hold_inst", inst, i0);
      chk("hold_valid", {31'b0, inst_valid}, 32'h1);
      chk("hold_req", {31'b0, imem_req}, 32'h0);
      chk("hold_cnt", retired_cnt, exp_cnt);
    end
    imem_ack     = 1'b0;
    inst_ready   = 1'b1;
    control_type = ctl;
    except       = exc;
    rs_data      = rs;
    @(negedge clock);
    inst_ready = 1'b0;
    except     = 1'b0;
    rs_data    = 32'h1234_5679;
    exp_cnt    = exp_cnt + 32'd1;
    chk("retired_cnt", retired_cnt, exp_cnt);
    chk("valid_clear", {31'b0, inst_valid}, 32'h0);
    chk("halted", {31'b0, halted}, {31'b0, exp_halt});
    chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
    if (exp_halt) begin
      chk("halt_pc", pc, exp_pc);
      chk("halt_req", {31'b0, imem_req}, 32'h0);
    end else begin
      chk("refetch_req", {31'b0, imem_req}, 32'h1);
      exp_q.push_back(exp_pc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ack_cyc;
    int unsigned prev_ack;

    reset        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    inst_ready   = 1'b0;
    control_type = 2'b00;
    except       = 1'b0;
    rs_data      = '0;
    prev_ack     = 0;

    //               word           ctl    rs             ack rdy  next
    vecs.push_back('{32'h2008_0001, 2'b00, 32'h1234_5679, 0, 0, 32'h0040_0004});
    vecs.push_back('{32'h2009_0002, 2'b00, 32'h1234_5679, 0, 0, 32'h0040_0008});
    vecs.push_back('{32'h0109_5020, 2'b00, 32'h1234_5679, 0, 0, 32'h0040_000C});
    vecs.push_back('{32'h0000_0000, 2'b00, 32'h1234_5679, 0, 0, 32'h0040_0010});
    vecs.push_back('{32'h1000_FFFE, 2'b01, 32'h1234_5679, 0, 0, 32'h0040_000C});
    vecs.push_back('{32'h0000_0000, 2'b00, 32'h1234_5679, 1, 0, 32'h0040_0010});
    vecs.push_back('{32'h1109_0003, 2'b01, 32'h1234_5679, 0, 1, 32'h0040_0020});
    vecs.push_back('{32'h03E0_0008, 2'b11, 32'h0040_001C, 0, 0, 32'h0040_001C});
    vecs.push_back('{32'h0810_0008, 2'b10, 32'h1234_5679, 0, 0, 32'h0040_0020});
    vecs.push_back('{32'h03E0_0008, 2'b11, 32'h0040_1000, 0, 0, 32'h0040_1000});
    vecs.push_back('{32'h8D0A_0004, 2'b00, 32'h1234_5679, 5, 3, 32'h0040_1004});
    vecs.push_back('{32'h0120_0008, 2'b11, 32'hF000_0000, 0, 0, 32'hF000_0000});
    vecs.push_back('{32'h0800_0040, 2'b10, 32'h1234_5679, 0, 0, 32'hF000_0100});
    vecs.push_back('{32'h0120_0008, 2'b11, 32'hFFFF_FFFC, 2, 0, 32'hFFFF_FFFC});
    vecs.push_back('{32'h1000_0001, 2'b01, 32'h1234_5679, 0, 0, 32'h0000_0004});
    vecs.push_back('{32'h1000_8000, 2'b01, 32'h1234_5679, 0, 2, 32'hFFFE_0008});
    vecs.push_back('{32'h0120_0008, 2'b11, 32'h0040_0008, 2, 1, 32'h0040_0008});

    apply_reset();

    foreach (vecs[i]) begin
      fetch(vecs[i].word, vecs[i].ack_dly, vecs[i].ack_dly > 2, ack_cyc);
      if (i == 1 || i == 2)
        chk("issue_interval", ack_cyc - prev_ack, 32'd2);
      prev_ack = ack_cyc;
      retire(vecs[i].ctl, 1'b0, vecs[i].rs, vecs[i].rdy_dly, vecs[i].exp_next, 1'b0, 1'b0);
    end

    // Exception at 0x00400008: halt with pc still on the faulting instruction
    fetch(32'h0000_000C, 0, 1'b0, ack_cyc);
    retire(2'b00, 1'b1, 32'h1234_5679, 0, 32'h0040_0008, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      inst_ready = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      @(negedge clock);
      chk("halt_stay", {31'b0, halted}, 32'h1);
      chk("halt_noreq", {31'b0, imem_req}, 32'h0);
      chk("halt_novalid", {31'b0, inst_valid}, 32'h0);
      chk("halt_cnt", retired_cnt, exp_cnt);
      chk("halt_pc_hold", pc, 32'h0040_0008);
    end
    inst_ready = 1'b0;
    imem_ack   = 1'b0;

    // Misaligned jr target: halt with misalign and pc at the bad target
    apply_reset();
    fetch(32'h03E0_0008, 0, 1'b0, ack_cyc);
    retire(2'b11, 1'b0, 32'h0040_0002, 0, 32'h0040_0002, 1'b1, 1'b1);
    @(negedge clock);
    chk("mis_stay", {31'b0, misalign}, 32'h1);
    chk("mis_pc", pc, 32'h0040_0002);

    // Reset during a pending fetch, with a late ack on the release cycle
    apply_reset();
    fetch(32'h2008_0007, 0, 1'b0, ack_cyc);
    retire(2'b00, 1'b0, 32'h1234_5679, 0, 32'h0040_0004, 1'b0, 1'b0);
    @(negedge clock);
    chk("pending_req", {31'b0, imem_req}, 32'h1);
    chk("pending_addr", imem_addr, 32'h0040_0004);
    reset = 1'b0;
    #1;
    chk("abort_req", {31'b0, imem_req}, 32'h0);
    chk("abort_pc", pc, RESET_PC);
    chk("abort_cnt", retired_cnt, 32'h0);
    @(negedge clock);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clock);
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'b0, inst_valid}, 32'h0);
    chk("late_ack_inst", inst, 32'h0);
    chk("late_ack_req", {31'b0, imem_req}, 32'h1);
    chk("late_ack_pc", pc, RESET_PC);
    exp_cnt = '0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    fetch(32'h2008_0008, 0, 1'b0, ack_cyc);
    retire(2'b00, 1'b0, 32'h1234_5679, 0, 32'h0040_0004, 1'b0, 1'b0);
    fetch(32'h0000_0000, 0, 1'b0, ack_cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
